// File: rtl/debouncer_multi.sv
// Multi-channel input debouncer: per-channel synchronizer, shared sample prescaler,
// per-channel stability counter, registered level plus one-cycle rise/fall/changed pulses.
module debouncer_multi #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned STABLE_CNT  = 5000,
  parameter int unsigned PRESC       = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        INIT_LEVEL  = 1'b0
) (
  input  logic            clk,
  input  logic            rst_a_p,
  input  logic [N_CH-1:0] din,
  output logic [N_CH-1:0] dout,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            changed
);

  localparam int unsigned CW = (STABLE_CNT < 1) ? 1 : $clog2(STABLE_CNT + 1);
  localparam int unsigned PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_CNT - 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC - 1);

  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
  logic [N_CH-1:0]                  s;
  logic [PW-1:0]                    presc_cnt;
  logic                             tick;
  logic [N_CH-1:0][CW-1:0]          cnt;
  logic [N_CH-1:0][CW-1:0]          cnt_nxt;
  logic [N_CH-1:0]                  dout_nxt;
  logic [N_CH-1:0]                  rise_nxt;
  logic [N_CH-1:0]                  fall_nxt;

  // Stage 0 samples din; the oldest stage feeds the debounce logic.
  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      sync_q <= {SYNC_STAGES{{N_CH{INIT_LEVEL}}}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign tick = (presc_cnt == PRESC_MAX);

  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  always_comb begin
    cnt_nxt  = cnt;
    dout_nxt = dout;
    rise_nxt = '0;
    fall_nxt = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (tick) begin
        if (s[i] == dout[i]) begin
          cnt_nxt[i] = '0;
        end else if (cnt[i] >= CNT_MAX) begin
          // >= rather than == so the counter can never run past its limit
          cnt_nxt[i]  = '0;
          dout_nxt[i] = s[i];
          rise_nxt[i] = s[i];
          fall_nxt[i] = ~s[i];
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      cnt     <= '0;
      dout    <= {N_CH{INIT_LEVEL}};
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      dout    <= dout_nxt;
      rise    <= rise_nxt;
      fall    <= fall_nxt;
      changed <= |(rise_nxt | fall_nxt);
    end
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// Scoreboard bench for debouncer_multi: expected pulse events are queued with their
// due cycle when stimulus is driven and matched whenever a DUT emits a pulse.
module tb_debouncer_multi;

  typedef struct {
    int         cyc;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] dout;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       rst_p3;
  logic [3:0] din;
  logic [3:0] din_p3;
  logic [3:0] dout, rise, fall;
  logic       changed;
  logic [3:0] dout_p3, rise_p3, fall_p3;
  logic       changed_p3;

  int  cyc      = 0;
  int  n_checks = 0;
  int  n_err    = 0;
  ev_t q0[$];
  ev_t q3[$];

  debouncer_multi #(
    .N_CH(4), .STABLE_CNT(4), .PRESC(1), .SYNC_STAGES(2), .INIT_LEVEL(1'b0)
  ) dut (
    .clk(clk), .rst_a_p(rst), .din(din),
    .dout(dout), .rise(rise), .fall(fall), .changed(changed)
  );

  debouncer_multi #(
    .N_CH(4), .STABLE_CNT(4), .PRESC(3), .SYNC_STAGES(2), .INIT_LEVEL(1'b0)
  ) dut_p3 (
    .clk(clk), .rst_a_p(rst_p3), .din(din_p3),
    .dout(dout_p3), .rise(rise_p3), .fall(fall_p3), .changed(changed_p3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push0(input logic [3:0] r, input logic [3:0] f, input logic [3:0] d, input int lat);
    q0.push_back('{cyc + lat, r, f, d});
  endtask

  task automatic push3(input logic [3:0] r, input logic [3:0] f, input logic [3:0] d, input int lat);
    q3.push_back('{cyc + lat, r, f, d});
  endtask

  // Pulse monitors sample on the falling edge, away from the DUT update edge.
  always @(negedge clk) begin
    if (changed || (|rise) || (|fall)) begin
      if (q0.size() == 0) begin
        check("p1_unexpected_pulse", 32'({changed, rise, fall}), 32'd0);
      end else begin
        ev_t e;
        e = q0.pop_front();
        check("p1_pulse_cycle", 32'(cyc), 32'(e.cyc));
        check("p1_rise", 32'(rise), 32'(e.rise));
        check("p1_fall", 32'(fall), 32'(e.fall));
        check("p1_changed", 32'(changed), 32'd1);
        check("p1_dout", 32'(dout), 32'(e.dout));
      end
    end
  end

  always @(negedge clk) begin
    if (changed_p3 || (|rise_p3) || (|fall_p3)) begin
      if (q3.size() == 0) begin
        check("p3_unexpected_pulse", 32'({changed_p3, rise_p3, fall_p3}), 32'd0);
      end else begin
        ev_t e;
        e = q3.pop_front();
        check("p3_pulse_cycle", 32'(cyc), 32'(e.cyc));
        check("p3_rise", 32'(rise_p3), 32'(e.rise));
        check("p3_fall", 32'(fall_p3), 32'(e.fall));
        check("p3_changed", 32'(changed_p3), 32'd1);
        check("p3_dout", 32'(dout_p3), 32'(e.dout));
      end
    end
  end

  initial begin
    bit bounce [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    din    = '0;
    din_p3 = '0;
    rst    = 1'b1;
    rst_p3 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_pulses", 32'({changed, rise, fall}), 32'd0);
    check("rst_p3_dout", 32'(dout_p3), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single channel rise, accepted on edge 6
    din = 4'b0001;
    push0(4'b0001, 4'b0000, 4'b0001, 6);
    repeat (5) @(negedge clk);
    check("ch0_before_accept", 32'(dout), 32'd0);
    repeat (5) @(negedge clk);
    check("ch0_dout", 32'(dout), 32'h1);
    check("ch0_q_empty", 32'(q0.size()), 32'd0);

    // Asynchronous reset mid-cycle, then restart with din[0] still high
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_dout", 32'(dout), 32'd0);
    check("async_rst_pulses", 32'({changed, rise, fall}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push0(4'b0001, 4'b0000, 4'b0001, 6);
    repeat (10) @(negedge clk);
    check("post_rst_q_empty", 32'(q0.size()), 32'd0);

    // Short glitch on ch1 must be rejected
    din[1] = 1'b1;
    repeat (3) @(negedge clk);
    din[1] = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_dout", 32'(dout), 32'h1);

    // Bounce on ch2, then settle high, then release
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      din[2] = bounce[i];
      if (i == 5) push0(4'b0100, 4'b0000, 4'b0101, 6);
    end
    repeat (10) @(negedge clk);
    check("bounce_dout", 32'(dout), 32'h5);
    check("bounce_q_empty", 32'(q0.size()), 32'd0);
    din[2] = 1'b0;
    push0(4'b0000, 4'b0100, 4'b0001, 6);
    repeat (10) @(negedge clk);
    check("ch2_fall_q_empty", 32'(q0.size()), 32'd0);

    // Return ch0 low, then two channels rise together
    din[0] = 1'b0;
    push0(4'b0000, 4'b0001, 4'b0000, 6);
    repeat (10) @(negedge clk);
    din = 4'b1001;
    push0(4'b1001, 4'b0000, 4'b1001, 6);
    repeat (10) @(negedge clk);
    check("dual_dout", 32'(dout), 32'h9);
    check("dual_q_empty", 32'(q0.size()), 32'd0);

    // Prescaled instance: reset after two counted ticks discards the partial count
    din_p3 = 4'b0001;
    rst_p3 = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_p3 = 1'b1;
    #1;
    check("p3_mid_rst_dout", 32'(dout_p3), 32'd0);
    check("p3_mid_rst_pulses", 32'({changed_p3, rise_p3, fall_p3}), 32'd0);
    repeat (2) @(negedge clk);
    rst_p3 = 1'b0;
    push3(4'b0001, 4'b0000, 4'b0001, 12);
    repeat (11) @(negedge clk);
    check("p3_before_accept", 32'(dout_p3), 32'd0);
    repeat (5) @(negedge clk);
    check("p3_dout", 32'(dout_p3), 32'h1);
    check("p3_q_empty", 32'(q3.size()), 32'd0);
    check("final_q0_empty", 32'(q0.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/debouncer_multi.md
DEBOUNCER_MULTI -- requirements
Module: debouncer_multi

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent input channels, 1..32.
REQ-002 SHALL have parameter STABLE_CNT, default 5000: consecutive differing samples required to accept a new level, 1 or more.
REQ-003 SHALL have parameter PRESC, default 1: clk cycles per sample tick, 1 or more.
REQ-004 SHALL have parameter SYNC_STAGES, default 2: input synchronizer flops per channel, 2..4.
REQ-005 SHALL have parameter INIT_LEVEL, default 0: reset level of every debounced output.
REQ-006 SHALL have port clk, input, 1 bit: clock, all state on rising edge.
REQ-007 SHALL have port rst_a_p, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port din, input, N_CH bits: raw asynchronous inputs.
REQ-009 SHALL have port dout, output, N_CH bits: debounced levels, registered.
REQ-010 SHALL have port rise, output, N_CH bits: one-cycle pulse when dout[i] goes 0 to 1.
REQ-011 SHALL have port fall, output, N_CH bits: one-cycle pulse when dout[i] goes 1 to 0.
REQ-012 SHALL have port changed, output, 1 bit: registered OR of rise and fall, coincident with them.

Function
REQ-013 SHALL pass each din[i] through a SYNC_STAGES-deep flop chain; the last stage is s[i].
REQ-014 SHALL run one shared prescaler counting 0..PRESC-1 and wrapping to 0; tick is high in the cycle the count equals PRESC-1, and is always high when PRESC=1.
REQ-015 SHALL give each channel a counter cnt[i] of width ceil(log2(STABLE_CNT+1)), minimum 1 bit.
REQ-016 On a tick with s[i] equal to dout[i], SHALL clear cnt[i] to 0; dout[i] is held.
REQ-017 On a tick with s[i] differing from dout[i] and cnt[i] below STABLE_CNT-1, SHALL increment cnt[i].
REQ-018 On a tick with s[i] differing from dout[i] and cnt[i] equal to STABLE_CNT-1, SHALL load dout[i] from s[i], clear cnt[i], and assert rise[i] or fall[i] in the same registered update.
REQ-019 On non-tick cycles, SHALL hold cnt[i] and dout[i], and SHALL drive rise, fall and changed to 0.
REQ-020 SHALL deassert rise, fall and changed the cycle after assertion; pulse width is exactly 1 clk.
REQ-021 Any mismatch shorter than STABLE_CNT consecutive ticks SHALL produce no dout change and no pulse.
REQ-022 SHALL treat channels independently; simultaneous acceptance on several channels SHALL assert each channel's pulse in the same cycle and changed once.
REQ-023 With PRESC=1 and a level held stable, dout SHALL follow a din change after exactly SYNC_STAGES+STABLE_CNT rising edges.
REQ-024 With STABLE_CNT=1, SHALL accept a new level on the first mismatching tick.
REQ-025 SHALL NOT let the counter exceed STABLE_CNT-1 or wrap.

Reset
REQ-026 While rst_a_p is high, SHALL immediately clear every synchronizer stage to INIT_LEVEL, clear every cnt to 0 and the prescaler to 0, set dout to INIT_LEVEL on all bits, and clear rise, fall and changed to 0.
REQ-027 A reset asserted mid-count SHALL discard partial counts; debouncing restarts from the first rising edge after release.
REQ-028 The first edge after release SHALL produce no pulse, even if din differs from INIT_LEVEL.

Verification (N_CH=4, STABLE_CNT=4, PRESC=1, SYNC_STAGES=2, INIT_LEVEL=0 unless stated)
REQ-029 Assert rst_a_p asynchronously mid-cycle -> dout=4'b0000, rise, fall and changed all 0 before the next clk edge.
REQ-030 Drive din[0] 0 to 1 and hold -> dout[0]=1 after rising edge 6; rise[0]=1 and changed=1 for that cycle only; fall=0.
REQ-031 Pulse din[1] high for 3 cycles -> dout[1] stays 0; no rise, fall or changed.
REQ-032 Drive din[2] through bounce 1,0,1,1,0 then hold 1 -> exactly one rise[2] pulse, 6 edges after the final 0-to-1 transition; then release to 0 -> exactly one fall[2].
REQ-033 Drive din[0] and din[3] 0 to 1 in the same cycle -> rise=4'b1001 in a single cycle; changed high for 1 cycle.
REQ-034 With PRESC=3, hold din[0] at 1, and assert rst_a_p after 2 accepted ticks -> cnt cleared and dout[0]=0; after release, dout[0] rises only after 4 fresh ticks (12 clk after synchronizer settles).
